cordic_engine_param: RTL and testbench

- Parametrised iterative CORDIC engine; next generation of the CORDIC control+datapath pair.
- Adds generic WIDTH and ITER, rotation and vectoring modes, full-circle quadrant pre-correction, start/done handshake and output saturation.
- Sits between the stimulus/register front end and the display/output logic.
- Performs one micro-rotation per clock.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/cordic_atan_rom.sv | 59 +++++
 rtl/cordic_engine_param.sv | 153 +++++++++++++++
 tb/tb_cordic_engine_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM state encoding, mode encoding and binary-angle constants.
// No logic; constants only, so no latency or backpressure.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // Binary angle scale: 2^(width-1) represents pi.
    function automatic int ANGLE_PI(input int width);
        return 1 << (width - 1);
    endfunction

    function automatic int ANGLE_HALF_PI(input int width);
        return 1 << (width - 2);
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent table atan(2^-i) in WIDTH-bit binary angle units, built at elaboration.
// Combinational lookup, zero latency; no handshake.
module cordic_atan_rom #(
    parameter  int WIDTH = 16,
    parameter  int ITER  = 14,
    localparam int CW    = $clog2(ITER)
) (
    input  logic [CW-1:0]    i,
    output logic [WIDTH-1:0] atan
);

    localparam int DEPTH = 1 << CW;

    // Reference angles with 2^32 = full circle; rescaled with rounding below.
    function automatic logic [31:0] atan_full(input int k);
        case (k)
            0:       return 32'h2000_0000;
            1:       return 32'h12E4_051E;
            2:       return 32'h09FB_385B;
            3:       return 32'h0511_11D4;
            4:       return 32'h028B_0D43;
            5:       return 32'h0145_D7E1;
            6:       return 32'h00A2_F61E;
            7:       return 32'h0051_7C55;
            8:       return 32'h0028_BE53;
            9:       return 32'h0014_5F2F;
            10:      return 32'h000A_2F98;
            11:      return 32'h0005_17CC;
            12:      return 32'h0002_8BE6;
            13:      return 32'h0001_45F3;
            14:      return 32'h0000_A2FA;
            15:      return 32'h0000_517D;
            16:      return 32'h0000_28BE;
            17:      return 32'h0000_145F;
            18:      return 32'h0000_0A30;
            19:      return 32'h0000_0518;
            20:      return 32'h0000_028C;
            21:      return 32'h0000_0146;
            22:      return 32'h0000_00A3;
            23:      return 32'h0000_0051;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] atan_scaled(input int k);
        logic [32:0] t;
        t = {1'b0, atan_full(k)} + (33'd1 << (31 - WIDTH));
        return t[32-WIDTH +: WIDTH];
    endfunction

    logic [WIDTH-1:0] tab [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tab
        assign tab[g] = (g < ITER) ? atan_scaled(g) : '0;
    end

    assign atan = tab[i];

endmodule

// File: rtl/cordic_engine_param.sv
// Iterative CORDIC (rotation/vectoring) with quadrant pre-correction and saturated outputs.
// done ITER+2 cycles after start is sampled; start is ignored while busy (no queuing).
module cordic_engine_param import cordic_pkg::*; #(
    parameter  int WIDTH = 16,
    parameter  int ITER  = 14,
    localparam int CW    = $clog2(ITER)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              state,
    output logic [CW-1:0]           i
);

    // Two guard bits cover the CORDIC gain and negation of the most negative input.
    localparam int XW = WIDTH + 2;

    localparam logic        [WIDTH-1:0] PI_W    = WIDTH'(ANGLE_PI(WIDTH));
    localparam logic signed [WIDTH-1:0] HALF_W  = WIDTH'(ANGLE_HALF_PI(WIDTH));
    localparam logic signed [XW-1:0]    SAT_MAX = XW'(ANGLE_PI(WIDTH) - 1);
    localparam logic signed [XW-1:0]    SAT_MIN = XW'(-ANGLE_PI(WIDTH));

    state_t state_q, state_d;

    logic                    mode_q;
    logic signed [XW-1:0]    x_q, y_q;
    logic signed [WIDTH-1:0] z_q;
    logic [CW-1:0]           i_q;

    logic signed [WIDTH-1:0] atan_i;
    logic signed [XW-1:0]    x_sh, y_sh, x_nxt, y_nxt;
    logic signed [WIDTH-1:0] z_nxt;
    logic                    dir;
    logic                    flip;
    logic                    last;

    cordic_atan_rom #(.WIDTH(WIDTH), .ITER(ITER)) u_rom (
        .i    (i_q),
        .atan (atan_i)
    );

    function automatic logic [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    assign x_sh = x_q >>> i_q;
    assign y_sh = y_q >>> i_q;
    assign last = (i_q == CW'(ITER - 1));

    // Fold the input into the right half-plane so every angle is within CORDIC range.
    assign flip = (mode_q == MODE_ROT) ? ((z_q > HALF_W) || (z_q < -HALF_W))
                                       : x_q[XW-1];

    always_comb begin
        dir   = (mode_q == MODE_ROT) ? ~z_q[WIDTH-1] : y_q[XW-1];
        x_nxt = x_q + y_sh;
        y_nxt = y_q - x_sh;
        z_nxt = z_q + atan_i;
        if (dir) begin
            x_nxt = x_q - y_sh;
            y_nxt = y_q + x_sh;
            z_nxt = z_q - atan_i;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                busy    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= MODE_ROT;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            i_q    <= '0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q <= mode;
                        x_q    <= {{2{x_in[WIDTH-1]}}, x_in};
                        y_q    <= {{2{y_in[WIDTH-1]}}, y_in};
                        z_q    <= z_in;
                    end
                end
                LOAD: begin
                    i_q <= '0;
                    if (flip) begin
                        x_q <= -x_q;
                        y_q <= -y_q;
                        z_q <= z_q + PI_W;
                    end
                end
                RUN: begin
                    x_q <= x_nxt;
                    y_q <= y_nxt;
                    z_q <= z_nxt;
                    if (last) begin
                        i_q   <= '0;
                        x_out <= sat(x_nxt);
                        y_out <= sat(y_nxt);
                        z_out <= z_nxt;
                    end else begin
                        i_q <= i_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;
    assign i     = i_q;

endmodule

// File: tb/tb_cordic_engine_param.sv
// Bench for cordic_engine_param: directed and random operations against a real-math model.
module tb_cordic_engine_param;

    localparam int WIDTH = 16;
    localparam int ITER  = 14;
    localparam int CW    = $clog2(ITER);
    localparam real PI   = 3.14159265358979;

    logic                    clk   = 1'b0;
    logic                    reset = 1'b0;
    logic                    start = 1'b0;
    logic                    mode  = 1'b0;
    logic signed [WIDTH-1:0] x_in  = '0;
    logic signed [WIDTH-1:0] y_in  = '0;
    logic signed [WIDTH-1:0] z_in  = '0;
    logic signed [WIDTH-1:0] x_out, y_out, z_out;
    logic                    busy, done;
    logic [1:0]              state;
    logic [CW-1:0]           i;

    int  tests = 0;
    int  fails = 0;
    real kgain;

    cordic_engine_param #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mode  (mode),
        .x_in  (x_in),
        .y_in  (y_in),
        .z_in  (z_in),
        .x_out (x_out),
        .y_out (y_out),
        .z_out (z_out),
        .busy  (busy),
        .done  (done),
        .state (state),
        .i     (i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp, input int tol);
        logic ok;
        tests++;
        ok = ((obs - exp) <= tol) && ((exp - obs) <= tol);
        assert (ok === 1'b1) else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // Angles compare modulo the full circle.
    task automatic check_ang(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp, input int tol);
        logic signed [31:0] d;
        logic ok;
        tests++;
        d = (obs - exp) & 32'sh0000_FFFF;
        if (d > 32767) d = d - 65536;
        ok = (d <= tol) && (d >= -tol);
        assert (ok === 1'b1) else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d +/- %0d (mod 65536)", tag, obs, exp, tol);
        end
    endtask

    function automatic int satr(input real v);
        if (v > 32767.0)  return 32767;
        if (v < -32768.0) return -32768;
        return int'(v);
    endfunction

    // Ideal result: gain-scaled rotation by z, or magnitude/angle of (x,y).
    task automatic model(input bit m, input int x, input int y, input int z,
                         output int ex, output int ey, output int ez);
        real a;
        if (m == 1'b0) begin
            a  = real'(z) * PI / 32768.0;
            ex = satr(kgain * (real'(x) * $cos(a) - real'(y) * $sin(a)));
            ey = satr(kgain * (real'(x) * $sin(a) + real'(y) * $cos(a)));
            ez = 0;
        end else begin
            ex = satr(kgain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
            ey = 0;
            ez = z + int'($atan2(real'(y), real'(x)) * 32768.0 / PI);
        end
    endtask

    task automatic scramble();
        mode = 1'($urandom);
        x_in = WIDTH'($urandom);
        y_in = WIDTH'($urandom);
        z_in = WIDTH'($urandom);
    endtask

    // Drive start at a falling edge; returns one falling edge after it was sampled.
    task automatic launch(input bit m, input int x, input int y, input int z);
        mode  = m;
        x_in  = WIDTH'(x);
        y_in  = WIDTH'(y);
        z_in  = WIDTH'(z);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_out(input string tag, input bit m, input int x, input int y, input int z,
                             input int tx, input int ty, input int tz);
        int ex, ey, ez;
        model(m, x, y, z, ex, ey, ez);
        check_near({tag, "_x"}, x_out, ex, tx);
        check_near({tag, "_y"}, y_out, ey, ty);
        check_ang({tag, "_z"}, z_out, ez, tz);
    endtask

    task automatic run_op(input string tag, input bit m, input int x, input int y, input int z,
                          input int tx, input int ty, input int tz);
        int lat;
        launch(m, x, y, z);
        wait_done(lat);
        check_eq({tag, "_lat"}, lat, ITER + 2);
        check_out(tag, m, x, y, z, tx, ty, tz);
        @(negedge clk);
        check_eq({tag, "_pulse"}, {31'd0, done}, 0);
        check_eq({tag, "_idle"}, {30'd0, state}, 0);
    endtask

    initial begin
        int lat, n, x, y, z;
        logic signed [WIDTH-1:0] ax, ay, az;
        bit held, seen, m;

        kgain = 1.0;
        for (int k = 0; k < ITER; k++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * k));

        repeat (2) @(negedge clk);
        check_eq("rst_state", {30'd0, state}, 0);
        check_eq("rst_i", {{(32-CW){1'b0}}, i}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_done", {31'd0, done}, 0);
        check_eq("rst_x", x_out, 0);
        check_eq("rst_y", y_out, 0);
        check_eq("rst_z", z_out, 0);
        reset = 1'b1;
        @(negedge clk);

        run_op("rot45", 1'b0, 9949, 0, 8192, 4, 4, 4);
        run_op("rot135", 1'b0, 9949, 0, 24576, 4, 4, 4);
        run_op("vec135", 1'b1, -10000, 10000, 0, 8, 4, 4);
        run_op("sat", 1'b0, 32767, 32767, 0, 0, 0, 4);

        // Back-to-back: start held in DONE, stray start pulse during RUN.
        launch(1'b0, 9949, 0, 8192);
        wait_done(lat);
        check_eq("b2b_a_lat", lat, ITER + 2);
        check_out("b2b_a", 1'b0, 9949, 0, 8192, 4, 4, 4);
        ax = x_out; ay = y_out; az = z_out;
        mode = 1'b1; x_in = -16'sd10000; y_in = 16'sd10000; z_in = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        check_eq("b2b_load", {30'd0, state}, 1);
        lat  = 1;
        held = 1'b1;
        while (done !== 1'b1 && lat < 200) begin
            start = (lat == 6);
            if (x_out !== ax || y_out !== ay || z_out !== az) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check_eq("b2b_hold", {31'd0, held}, 1);
        check_eq("b2b_b_lat", lat, ITER + 2);
        check_out("b2b_b", 1'b1, -10000, 10000, 0, 8, 4, 4);
        @(negedge clk);
        check_eq("b2b_idle", {30'd0, state}, 0);

        // Reset in the middle of RUN.
        launch(1'b0, 5000, 3000, 1000);
        n = 0;
        while (i !== CW'(5) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_i5", {{(32-CW){1'b0}}, i}, 5);
        reset = 1'b0;
        #1;
        check_eq("mid_state", {30'd0, state}, 0);
        check_eq("mid_i", {{(32-CW){1'b0}}, i}, 0);
        check_eq("mid_busy", {31'd0, busy}, 0);
        check_eq("mid_x", x_out, 0);
        check_eq("mid_y", y_out, 0);
        check_eq("mid_z", z_out, 0);
        @(negedge clk);
        reset = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < ITER + 4; k++) begin
            @(negedge clk);
            if (done !== 1'b0) seen = 1'b1;
        end
        check_eq("mid_nodone", {31'd0, seen}, 0);

        for (int k = 0; k < 24; k++) begin
            m = k[0];
            do begin
                x = int'($urandom_range(0, 40000)) - 20000;
                y = int'($urandom_range(0, 40000)) - 20000;
            end while (x * x + y * y < 64000000);
            z = int'($urandom_range(0, 65535)) - 32768;
            if (m) run_op("rnd_vec", 1'b1, x, y, z, 40, 16, 24);
            else   run_op("rnd_rot", 1'b0, x, y, z, 40, 40, 4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
